// File: rtl/signal_history_tracker_if.sv
// Bundle of the sample feed, the query request and the query response of
// signal_history_tracker.
//   master : the feeder/querier (drives counter, tracked_signal, req_*).
//   slave  : the tracker (drives req_ready, rsp_*).
// Parameters must match those given to the tracker instance.
interface signal_history_tracker_if #(
  parameter int unsigned TRACKED_SIGNAL_WIDTH = 1,
  parameter int unsigned NUM_CHANNELS         = 2,
  parameter int unsigned HISTORY_DEPTH        = 16
);
  localparam int unsigned W  = TRACKED_SIGNAL_WIDTH;
  localparam int unsigned CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int unsigned DW = $clog2(HISTORY_DEPTH);

  logic [31:0]               counter;
  logic [NUM_CHANNELS*W-1:0] tracked_signal;

  logic                      req_valid;
  logic                      req_ready;
  logic                      req_mode;
  logic [CW-1:0]             req_channel;
  logic [DW:0]               req_cycles_back;
  logic [W-1:0]              req_value;

  logic                      rsp_valid;
  logic                      rsp_found;
  logic [W-1:0]              rsp_signal;
  logic signed [31:0]        rsp_time_start;
  logic signed [31:0]        rsp_time_end;

  modport master (
    output counter, tracked_signal,
    output req_valid, req_mode, req_channel, req_cycles_back, req_value,
    input  req_ready,
    input  rsp_valid, rsp_found, rsp_signal, rsp_time_start, rsp_time_end
  );

  modport slave (
    input  counter, tracked_signal,
    input  req_valid, req_mode, req_channel, req_cycles_back, req_value,
    output req_ready,
    output rsp_valid, rsp_found, rsp_signal, rsp_time_start, rsp_time_end
  );
endinterface

// File: rtl/signal_history_tracker.sv
// signal_history_tracker
// Keeps a circular history of the last HISTORY_DEPTH samples of NUM_CHANNELS
// channels, each tagged with the free-running counter, and answers queries:
//   VALUE_FIND (mode 0): channel value req_cycles_back samples ago.
//   TIME_TEST  (mode 1): start/end timestamps of the newest contiguous run in
//                        which the channel equalled req_value.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : slave modport of signal_history_tracker_if (samples, request,
//           one-cycle response pulse without back-pressure)
module signal_history_tracker #(
  parameter int unsigned TRACKED_SIGNAL_WIDTH = 1,
  parameter int unsigned NUM_CHANNELS         = 2,
  parameter int unsigned HISTORY_DEPTH        = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  signal_history_tracker_if.slave   bus
);
  localparam int unsigned W  = TRACKED_SIGNAL_WIDTH;
  localparam int unsigned CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int unsigned DW = $clog2(HISTORY_DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StScanMatch,
    StScanRun,
    StDone
  } state_e;

  state_e state_q, state_d;

  // History storage; contents need no reset, fill_q says what is valid.
  logic [NUM_CHANNELS*W-1:0] sig_mem [HISTORY_DEPTH];
  logic [31:0]               ts_mem  [HISTORY_DEPTH];

  logic [DW-1:0] wr_ptr_q, wr_ptr_d;
  logic [DW:0]   fill_q, fill_d;
  logic          cap_en;

  // Request fields latched on acceptance.
  logic          mode_q, mode_d;
  logic          bad_q, bad_d;
  logic [CW-1:0] chan_q, chan_d;
  logic [DW:0]   back_q, back_d;
  logic [W-1:0]  value_q, value_d;

  // Scan progress and result.
  logic [DW-1:0] age_q, age_d;
  logic          found_q, found_d;
  logic [31:0]   start_q, start_d;
  logic [31:0]   end_q, end_d;

  // Registered response.
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_found_q, rsp_found_d;
  logic [W-1:0]  rsp_signal_q, rsp_signal_d;
  logic [31:0]   rsp_start_q, rsp_start_d;
  logic [31:0]   rsp_end_q, rsp_end_d;

  // Read port shared by READ (age = cycles back) and the scan states.
  logic [DW-1:0]             rd_age;
  logic [DW-1:0]             rd_idx;
  logic [NUM_CHANNELS*W-1:0] rd_word;
  logic [31:0]               rd_ts;
  logic [W-1:0]              rd_val;
  logic                      rd_last;
  logic                      rd_match;
  logic                      vf_found;
  logic                      req_bad;

  // Frozen from the edge after a TIME_TEST acceptance through its response edge.
  assign cap_en = (state_q == StIdle) || ((state_q == StRead) && !mode_q);

  assign rd_age  = (state_q == StRead) ? back_q[DW-1:0] : age_q;
  // Age 0 is the newest entry, one behind the write pointer.
  assign rd_idx  = wr_ptr_q - DW'(1) - rd_age;
  assign rd_word = sig_mem[rd_idx];
  assign rd_ts   = ts_mem[rd_idx];

  always_comb begin
    rd_val = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (CW'(c) == chan_q) rd_val = rd_word[c*W +: W];
    end
  end

  assign rd_match = (rd_val == value_q);
  assign rd_last  = ({1'b0, age_q} == (fill_q - (DW+1)'(1)));
  assign vf_found = !bad_q && (back_q < fill_q);
  assign req_bad  = 32'(bus.req_channel) >= NUM_CHANNELS;

  always_ff @(posedge clk) begin
    if (cap_en) begin
      sig_mem[wr_ptr_q] <= bus.tracked_signal;
      ts_mem[wr_ptr_q]  <= bus.counter;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    if (cap_en) begin
      wr_ptr_d = wr_ptr_q + DW'(1);
      if (fill_q != (DW+1)'(HISTORY_DEPTH)) fill_d = fill_q + (DW+1)'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    bad_d        = bad_q;
    chan_d       = chan_q;
    back_d       = back_q;
    value_d      = value_q;
    age_d        = age_q;
    found_d      = found_q;
    start_d      = start_q;
    end_d        = end_q;
    rsp_valid_d  = 1'b0;
    rsp_found_d  = rsp_found_q;
    rsp_signal_d = rsp_signal_q;
    rsp_start_d  = rsp_start_q;
    rsp_end_d    = rsp_end_q;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          mode_d  = bus.req_mode;
          bad_d   = req_bad;
          chan_d  = bus.req_channel;
          back_d  = bus.req_cycles_back;
          value_d = bus.req_value;
          age_d   = '0;
          found_d = 1'b0;
          start_d = '1;
          end_d   = '1;
          state_d = (req_bad || !bus.req_mode) ? StRead : StScanMatch;
        end
      end
      StRead: begin
        rsp_valid_d  = 1'b1;
        rsp_found_d  = vf_found;
        rsp_signal_d = vf_found ? rd_val : '0;
        rsp_start_d  = '1;
        rsp_end_d    = '1;
        state_d      = StIdle;
      end
      StScanMatch: begin
        if (fill_q == '0) begin
          state_d = StDone;
        end else if (rd_match) begin
          found_d = 1'b1;
          end_d   = rd_ts;
          start_d = rd_ts;
          if (rd_last) begin
            state_d = StDone;
          end else begin
            age_d   = age_q + DW'(1);
            state_d = StScanRun;
          end
        end else if (rd_last) begin
          state_d = StDone;
        end else begin
          age_d = age_q + DW'(1);
        end
      end
      StScanRun: begin
        if (rd_match) begin
          start_d = rd_ts;
          if (rd_last) state_d = StDone;
          else         age_d   = age_q + DW'(1);
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        rsp_valid_d  = 1'b1;
        rsp_found_d  = found_q;
        rsp_signal_d = '0;
        rsp_start_d  = start_q;
        rsp_end_d    = end_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      fill_q       <= '0;
      mode_q       <= 1'b0;
      bad_q        <= 1'b0;
      chan_q       <= '0;
      back_q       <= '0;
      value_q      <= '0;
      age_q        <= '0;
      found_q      <= 1'b0;
      start_q      <= '1;
      end_q        <= '1;
      rsp_valid_q  <= 1'b0;
      rsp_found_q  <= 1'b0;
      rsp_signal_q <= '0;
      rsp_start_q  <= '1;
      rsp_end_q    <= '1;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      fill_q       <= fill_d;
      mode_q       <= mode_d;
      bad_q        <= bad_d;
      chan_q       <= chan_d;
      back_q       <= back_d;
      value_q      <= value_d;
      age_q        <= age_d;
      found_q      <= found_d;
      start_q      <= start_d;
      end_q        <= end_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_found_q  <= rsp_found_d;
      rsp_signal_q <= rsp_signal_d;
      rsp_start_q  <= rsp_start_d;
      rsp_end_q    <= rsp_end_d;
    end
  end

  assign bus.req_ready      = (state_q == StIdle);
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_found      = rsp_found_q;
  assign bus.rsp_signal     = rsp_signal_q;
  assign bus.rsp_time_start = rsp_start_q;
  assign bus.rsp_time_end   = rsp_end_q;
endmodule
